// File: rtl/serial_comparator_multichannel_framed_if.sv
// Beat/result bundle for serial_comparator_multichannel_framed.
// master drives the serial beats and reads results; slave is the comparator.
interface serial_comparator_multichannel_framed_if #(
    parameter int N_CH    = 4,
    parameter int MAX_LEN = 32
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic              in_valid;
    logic              in_last;
    logic              msb_first;
    logic [N_CH-1:0]   a;
    logic [N_CH-1:0]   b;
    logic              out_valid;
    logic [N_CH-1:0]   out_less;
    logic [N_CH-1:0]   out_eq;
    logic [N_CH-1:0]   out_greater;
    logic [LEN_W-1:0]  out_len;
    logic              out_ovf;

    modport master (
        output in_valid, in_last, msb_first, a, b,
        input  out_valid, out_less, out_eq, out_greater, out_len, out_ovf
    );

    modport slave (
        input  in_valid, in_last, msb_first, a, b,
        output out_valid, out_less, out_eq, out_greater, out_len, out_ovf
    );
endinterface

// File: rtl/serial_comparator_multichannel_framed.sv
// Framed N_CH-channel bit-serial magnitude comparator with per-frame bit order.
// Optional SERIAL_CMP_SIGNED_EN: two's-complement operands (sign-bit beat inverts sense).
module serial_comparator_multichannel_framed #(
    parameter int N_CH    = 4,
    parameter int MAX_LEN = 32,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic clk,
    input  logic rst_n,
    serial_comparator_multichannel_framed_if.slave bus
);

    typedef enum logic {S_IDLE, S_BUSY} fsm_t;

    localparam logic [1:0] CH_EQ = 2'd0;
    localparam logic [1:0] CH_LT = 2'd1;
    localparam logic [1:0] CH_GT = 2'd2;

    fsm_t state_q, state_d;
    logic first_beat, last_beat;

    logic                  order_q;
    logic                  ord_msb;
    logic                  sign_beat;
    logic [N_CH-1:0][1:0]  ch_q, ch_d;
    logic [N_CH-1:0]       lt_v, gt_v;
    logic [LEN_W-1:0]      len_q, len_d, len_base;
    logic                  ovf_q, ovf_d, ovf_base, at_max;

    logic                  out_valid_q;
    logic [N_CH-1:0]       out_less_q, out_eq_q, out_greater_q;
    logic [N_CH-1:0]       less_d, eq_d, greater_d;
    logic [LEN_W-1:0]      out_len_q;
    logic                  out_ovf_q;

    // One beat of the per-channel verdict update. MSB-first locks on the
    // first difference; LSB-first lets the most recent difference win.
    function automatic logic [1:0] cmp_step(input logic [1:0] cur, input logic msb,
                                            input logic lt, input logic gt);
        logic [1:0] nxt;
        nxt = cur;
        if (!msb || cur == CH_EQ) begin
            if (lt)      nxt = CH_LT;
            else if (gt) nxt = CH_GT;
        end
        return nxt;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid && !bus.in_last) state_d = S_BUSY;
            S_BUSY:  if (bus.in_valid &&  bus.in_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        first_beat = 1'b0;
        last_beat  = 1'b0;
        if (bus.in_valid) begin
            first_beat = (state_q == S_IDLE);
            last_beat  = bus.in_last;
        end
    end

    // Beat evaluation: the first beat starts from EQ and a zero length, never
    // from whatever the previous frame left behind.
    always_comb begin
        ord_msb   = first_beat ? bus.msb_first : order_q;
        sign_beat = 1'b0;
`ifdef SERIAL_CMP_SIGNED_EN
        sign_beat = ord_msb ? first_beat : last_beat;
`endif
        lt_v = sign_beat ? (bus.a & ~bus.b) : (~bus.a & bus.b);
        gt_v = sign_beat ? (~bus.a & bus.b) : (bus.a & ~bus.b);
        for (int c = 0; c < N_CH; c++) begin
            ch_d[c]      = cmp_step(first_beat ? CH_EQ : ch_q[c], ord_msb, lt_v[c], gt_v[c]);
            less_d[c]    = (ch_d[c] == CH_LT);
            eq_d[c]      = (ch_d[c] == CH_EQ);
            greater_d[c] = (ch_d[c] == CH_GT);
        end
        len_base = first_beat ? '0   : len_q;
        ovf_base = first_beat ? 1'b0 : ovf_q;
        at_max   = (len_base == LEN_W'(MAX_LEN));
        len_d    = at_max ? len_base : len_base + LEN_W'(1);
        ovf_d    = ovf_base | at_max;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            order_q       <= 1'b0;
            ch_q          <= '0;
            len_q         <= '0;
            ovf_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            out_less_q    <= '0;
            out_eq_q      <= '1;
            out_greater_q <= '0;
            out_len_q     <= '0;
            out_ovf_q     <= 1'b0;
        end else begin
            out_valid_q <= last_beat;
            if (bus.in_valid) begin
                order_q <= ord_msb;
                ch_q    <= ch_d;
                len_q   <= len_d;
                ovf_q   <= ovf_d;
            end
            if (last_beat) begin
                out_less_q    <= less_d;
                out_eq_q      <= eq_d;
                out_greater_q <= greater_d;
                out_len_q     <= len_d;
                out_ovf_q     <= ovf_d;
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_less    = out_less_q;
    assign bus.out_eq      = out_eq_q;
    assign bus.out_greater = out_greater_q;
    assign bus.out_len     = out_len_q;
    assign bus.out_ovf     = out_ovf_q;

endmodule

// File: tb/tb_serial_comparator_multichannel_framed.sv
// Directed bench for serial_comparator_multichannel_framed (N_CH=2, MAX_LEN=4).
// Expectations follow SERIAL_CMP_SIGNED_EN when the bench is built with it.
module tb_serial_comparator_multichannel_framed;

`ifdef SERIAL_CMP_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    localparam logic [2:0] V_LT = 3'b100;
    localparam logic [2:0] V_EQ = 3'b010;
    localparam logic [2:0] V_GT = 3'b001;

    logic clk = 1'b0;
    logic rst_n;
    int   compared   = 0;
    int   mismatched = 0;

    serial_comparator_multichannel_framed_if #(.N_CH(2), .MAX_LEN(4)) bus ();

    serial_comparator_multichannel_framed #(.N_CH(2), .MAX_LEN(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input string tag, input logic [2:0] e0, input logic [2:0] e1,
                               input int elen, input logic eovf);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".ch0"}, 32'({bus.out_less[0], bus.out_eq[0], bus.out_greater[0]}), 32'(e0));
        chk({tag, ".ch1"}, 32'({bus.out_less[1], bus.out_eq[1], bus.out_greater[1]}), 32'(e1));
        chk({tag, ".len"}, 32'(bus.out_len), 32'(elen));
        chk({tag, ".ovf"}, 32'(bus.out_ovf), 32'(eovf));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".valid"},   32'(bus.out_valid),   32'd0);
        chk({tag, ".less"},    32'(bus.out_less),    32'd0);
        chk({tag, ".eq"},      32'(bus.out_eq),      32'd3);
        chk({tag, ".greater"}, 32'(bus.out_greater), 32'd0);
        chk({tag, ".len"},     32'(bus.out_len),     32'd0);
        chk({tag, ".ovf"},     32'(bus.out_ovf),     32'd0);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends len beats; bubbles carry junk data, in_last=1 and a flipped order bit.
    task automatic send(input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] a1,
                        input logic [7:0] b1, input int len, input bit msb, input bit bub,
                        input bit with_last);
        int idx;
        for (int i = 0; i < len; i++) begin
            idx = msb ? (len - 1 - i) : i;
            if (bub && i > 0) begin
                bus.in_valid  = 1'b0;
                bus.in_last   = 1'b1;
                bus.msb_first = ~msb;
                bus.a         = ~{a1[idx], a0[idx]};
                bus.b         = ~{b1[idx], b0[idx]};
                @(posedge clk);
                #1;
            end
            bus.in_valid  = 1'b1;
            bus.in_last   = with_last && (i == len - 1);
            bus.msb_first = (i == 0) ? msb : ~msb;
            bus.a         = {a1[idx], a0[idx]};
            bus.b         = {b1[idx], b0[idx]};
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.msb_first = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic MSB-first, then hold/one-cycle pulse checks
        send(8'b0110, 8'b0101, 8'b1001, 8'b1001, 4, 1'b1, 1'b0, 1'b1);
        check_frame("msb4", V_GT, V_EQ, 4, 1'b0);
        idle(1);
        chk("msb4.pulse_end", 32'(bus.out_valid), 32'd0);
        chk("msb4.hold", 32'(bus.out_greater), 32'd1);

        // Basic LSB-first, same values
        send(8'b0110, 8'b0101, 8'b1001, 8'b1001, 4, 1'b0, 1'b0, 1'b1);
        check_frame("lsb4", V_GT, V_EQ, 4, 1'b0);
        idle(2);

        // LSB-first with bubbles between beats
        send(8'b0110, 8'b0101, 8'b1001, 8'b1001, 4, 1'b0, 1'b1, 1'b1);
        check_frame("lsb4bub", V_GT, V_EQ, 4, 1'b0);
        idle(1);

        // Back-to-back: MSB-first 3-bit then LSB-first 3-bit, no gap
        send(8'b100, 8'b011, 8'b010, 8'b011, 3, 1'b1, 1'b0, 1'b1);
        check_frame("b2b_a", SGN ? V_LT : V_GT, V_LT, 3, 1'b0);
        send(8'b100, 8'b011, 8'b101, 8'b101, 3, 1'b0, 1'b0, 1'b1);
        check_frame("b2b_b", SGN ? V_LT : V_GT, V_EQ, 3, 1'b0);
        idle(1);
        chk("b2b.pulse_end", 32'(bus.out_valid), 32'd0);

        // Overflow: 6 beats with MAX_LEN=4, decided on the final bit
        send(8'b000001, 8'b000000, 8'b000000, 8'b000010, 6, 1'b1, 1'b0, 1'b1);
        check_frame("ovf6", V_GT, V_LT, 4, 1'b1);
        idle(1);

        // Sign-sensitive vectors; ovf must clear on a normal frame
        send(8'b1111, 8'b0001, 8'b0011, 8'b0011, 4, 1'b1, 1'b0, 1'b1);
        check_frame("sgn_msb", SGN ? V_LT : V_GT, V_EQ, 4, 1'b0);
        idle(1);
        send(8'b0111, 8'b1000, 8'b0001, 8'b0000, 4, 1'b0, 1'b0, 1'b1);
        check_frame("sgn_lsb", SGN ? V_GT : V_LT, V_GT, 4, 1'b0);
        idle(1);
        send(8'b1, 8'b0, 8'b0, 8'b1, 1, 1'b1, 1'b0, 1'b1);
        check_frame("bit1", SGN ? V_LT : V_GT, SGN ? V_GT : V_LT, 1, 1'b0);
        idle(1);

        // Reset in the middle of a frame
        send(8'b11, 8'b00, 8'b00, 8'b00, 2, 1'b1, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        rst_n        = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("midrst.no_pulse", 32'(bus.out_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst.after", 32'(bus.out_valid), 32'd0);
        send(8'b01, 8'b10, 8'b11, 8'b11, 2, 1'b0, 1'b0, 1'b1);
        check_frame("postrst", SGN ? V_GT : V_LT, V_EQ, 2, 1'b0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
